// File: rtl/reg_file_reversed.sv
// Register file with one write port (writes on every clock) and one
// combinational read port that can return the stored word bit-reversed.
module reg_file_reversed #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter bit REVERSE    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] readReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] readData
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_word_rev;

  function automatic logic [DATA_WIDTH-1:0] bit_reverse(
    input logic [DATA_WIDTH-1:0] d
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = d[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  // Reset wins over the unconditional write issued on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_mem[writeReg] <= writeData;
    end
  end

  // No write-to-read bypass: reads always see the registered contents.
  assign w_word     = r_mem[readReg];
  assign w_word_rev = bit_reverse(w_word);

  generate
    if (REVERSE) begin : g_rev
      assign readData = w_word_rev;
    end else begin : g_fwd
      assign readData = w_word;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_reversed.sv
// Bench for reg_file_reversed: default 2x1 instance plus 4x8 instances with
// and without reversal, compared against an array model of the contents.
module tb_reg_file_reversed;

  logic       clk;
  logic       rst_n;
  logic       s_rd, s_wd, s_wr, s_q;
  logic [1:0] w_rd, w_wr;
  logic [7:0] w_wd, q_rev, q_fwd;

  int checks   = 0;
  int failures = 0;

  logic       ms [2];
  logic [7:0] mw [4];

  reg_file_reversed dut_s (
    .clk(clk), .rst_n(rst_n), .readReg(s_rd), .writeData(s_wd),
    .writeReg(s_wr), .readData(s_q)
  );

  reg_file_reversed #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .REVERSE(1'b1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .readReg(w_rd), .writeData(w_wd),
    .writeReg(w_wr), .readData(q_rev)
  );

  reg_file_reversed #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .REVERSE(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .readReg(w_rd), .writeData(w_wd),
    .writeReg(w_wr), .readData(q_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the same rule the block should.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      ms[0] = 1'b0; ms[1] = 1'b0;
      for (int i = 0; i < 4; i++) mw[i] = 8'h00;
    end else begin
      ms[s_wr] = s_wd;
      mw[w_wr] = w_wd;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] v, rv;
    v  = mw[w_rd];
    rv = {<<{v}};
    chk({tag, "_s"},   {7'b0, s_q}, {7'b0, ms[s_rd]});
    chk({tag, "_rev"}, q_rev, rv);
    chk({tag, "_fwd"}, q_fwd, v);
  endtask

  initial begin
    rst_n = 1'b0;
    s_rd = 1'b0; s_wd = 1'b0; s_wr = 1'b0;
    w_rd = 2'd0; w_wd = 8'h00; w_wr = 2'd0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_init_s", {7'b0, s_q}, 8'h00);
    chk("rst_init_rev", q_rev, 8'h00);

    // Reset clears everything and suppresses the concurrent write.
    s_wr = 1'b0; s_wd = 1'b1; step();
    s_wr = 1'b1; step();
    s_rd = 1'b0; #1 chk("pre_rst_e0", {7'b0, s_q}, 8'h01);
    s_rd = 1'b1; #1 chk("pre_rst_e1", {7'b0, s_q}, 8'h01);
    rst_n = 1'b0; s_wr = 1'b0; s_wd = 1'b1; step();
    rst_n = 1'b1; s_wd = 1'b0;
    s_rd = 1'b0; #1 chk("rst_e0", {7'b0, s_q}, 8'h00);
    s_rd = 1'b1; #1 chk("rst_e1", {7'b0, s_q}, 8'h00);

    // Basic write: invisible before the edge, visible right after.
    s_wr = 1'b1; s_wd = 1'b1; s_rd = 1'b1; #1;
    chk("wr_before", {7'b0, s_q}, 8'h00);
    step();
    chk("wr_after", {7'b0, s_q}, 8'h01);
    s_rd = 1'b0; #1 chk("wr_other", {7'b0, s_q}, 8'h00);

    // No enable: the next edge overwrites.
    s_wd = 1'b0; s_wr = 1'b1; step();
    s_rd = 1'b1; #1 chk("wr_every", {7'b0, s_q}, 8'h00);

    // Same-address read/write has no bypass.
    s_rd = 1'b0; s_wr = 1'b0; s_wd = 1'b1; #1;
    chk("same_before", {7'b0, s_q}, 8'h00);
    step();
    chk("same_after", {7'b0, s_q}, 8'h01);
    s_rd = 1'b1; #1 chk("same_other", {7'b0, s_q}, 8'h00);

    // Reversal on the wide configuration.
    w_wr = 2'd2; w_wd = 8'h01; step();
    w_wr = 2'd3; w_wd = 8'hA3; step();
    w_rd = 2'd2; #1;
    chk("rev_e2", q_rev, 8'h80);
    chk("fwd_e2", q_fwd, 8'h01);
    w_rd = 2'd3; #1;
    chk("rev_e3", q_rev, 8'hC5);
    chk("fwd_e3", q_fwd, 8'hA3);

    // Mid-run reset after filling with all ones.
    w_wd = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      w_wr = i[1:0]; step();
    end
    for (int i = 0; i < 4; i++) begin
      w_rd = i[1:0]; #1;
      chk("fill_fwd", q_fwd, 8'hFF);
    end
    rst_n = 1'b0; w_wr = 2'd0; step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_rd = i[1:0]; #1;
      chk("mid_rst_rev", q_rev, 8'h00);
      chk("mid_rst_fwd", q_fwd, 8'h00);
    end
    w_wr = 2'd1; w_wd = 8'h12; step();
    w_rd = 2'd1; #1;
    chk("resume_rev", q_rev, 8'h48);
    chk("resume_fwd", q_fwd, 8'h12);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      s_wr  = 1'($urandom_range(0, 1));
      s_wd  = 1'($urandom_range(0, 1));
      w_wr  = 2'($urandom_range(0, 3));
      w_wd  = 8'($urandom);
      s_rd  = 1'($urandom_range(0, 1));
      w_rd  = 2'($urandom_range(0, 3));
      #1 check_model("rnd_pre");
      step();
      check_model("rnd_post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
